battleship_turn_ctrl: RTL and testbench

Turn scheduler for the 5x5 battleship game. Alternates firing rights between the human player and the PC, and enforces the per-turn time limit. Arbitrates one shared shot port into the board/hit-check datapath, counts hits, and declares win/lose. Sits between the switch/button front end, the PC move generator and the board logic.

---
 rtl/battleship_turn_ctrl_if.sv | 38 +++
 rtl/battleship_turn_ctrl.sv | 140 ++++++++++++++
 tb/tb_battleship_turn_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/battleship_turn_ctrl_if.sv
// Shot/turn bus between the battleship turn controller and its neighbours
// (front end, PC move generator, board datapath).
interface battleship_turn_ctrl_if;
   logic       start;
   logic       fire_req;
   logic [2:0] sel_row;
   logic [2:0] sel_col;
   logic       pc_valid;
   logic [2:0] pc_row;
   logic [2:0] pc_col;
   logic       shot_valid;
   logic       shot_target;
   logic [2:0] shot_row;
   logic [2:0] shot_col;
   logic       shot_done;
   logic       shot_hit;
   logic       shot_repeat;
   logic       turn;
   logic [3:0] seconds_left;
   logic [2:0] player_score;
   logic [2:0] pc_score;
   logic       player_win;
   logic       player_lose;

   modport master (
      input  start, fire_req, sel_row, sel_col, pc_valid, pc_row, pc_col,
             shot_done, shot_hit, shot_repeat,
      output shot_valid, shot_target, shot_row, shot_col, turn, seconds_left,
             player_score, pc_score, player_win, player_lose
   );

   modport slave (
      output start, fire_req, sel_row, sel_col, pc_valid, pc_row, pc_col,
             shot_done, shot_hit, shot_repeat,
      input  shot_valid, shot_target, shot_row, shot_col, turn, seconds_left,
             player_score, pc_score, player_win, player_lose
   );
endinterface

// File: rtl/battleship_turn_ctrl.sv
// Battleship turn scheduler: player/PC turn alternation, per-turn timer, shared shot port, scoring.
// Optional BONUS_TURN_EN: a non-winning hit gives the shooter another turn.
module battleship_turn_ctrl #(
   parameter int TICK_CYCLES  = 50000000,
   parameter int TURN_SECONDS = 15,
   parameter int SHIPS        = 5
) (
   input logic                    clk,
   input logic                    rst,
   battleship_turn_ctrl_if.master bus
);
   localparam int              TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [3:0]      SECS      = 4'(TURN_SECONDS);
   localparam logic [2:0]      WIN       = 3'(SHIPS);

   typedef enum logic [2:0] {IDLE, P_TURN, P_SHOT, PC_TURN, PC_SHOT, GAME_OVER} state_t;

   state_t        state;
   logic [TW-1:0] tick;
   logic          sel_ok, pc_ok, again;
   logic [2:0]    p_inc, pc_inc;

   assign sel_ok = (bus.sel_row <= 3'd4) && (bus.sel_col <= 3'd4);
   assign pc_ok  = (bus.pc_row  <= 3'd4) && (bus.pc_col  <= 3'd4);
   assign p_inc  = (bus.player_score == WIN) ? bus.player_score : bus.player_score + 3'd1;
   assign pc_inc = (bus.pc_score == WIN) ? bus.pc_score : bus.pc_score + 3'd1;
`ifdef BONUS_TURN_EN
   assign again  = bus.shot_hit;
`else
   assign again  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         tick             <= '0;
         bus.shot_valid   <= 1'b0;
         bus.shot_target  <= 1'b0;
         bus.shot_row     <= 3'd0;
         bus.shot_col     <= 3'd0;
         bus.turn         <= 1'b0;
         bus.seconds_left <= 4'd0;
         bus.player_score <= 3'd0;
         bus.pc_score     <= 3'd0;
         bus.player_win   <= 1'b0;
         bus.player_lose  <= 1'b0;
      end else begin
         case (state)
            IDLE, GAME_OVER: begin
               if (bus.start) begin
                  bus.player_score <= 3'd0;
                  bus.pc_score     <= 3'd0;
                  bus.player_win   <= 1'b0;
                  bus.player_lose  <= 1'b0;
                  bus.seconds_left <= SECS;
                  bus.turn         <= 1'b0;
                  tick             <= '0;
                  state            <= P_TURN;
               end
            end
            P_TURN: begin
               // A fire on the final tick beats the forfeit; the timer freezes during the shot.
               if (bus.fire_req && sel_ok) begin
                  bus.shot_row    <= bus.sel_row;
                  bus.shot_col    <= bus.sel_col;
                  bus.shot_target <= 1'b0;
                  bus.shot_valid  <= 1'b1;
                  state           <= P_SHOT;
               end else if (tick == TICK_LAST) begin
                  tick <= '0;
                  if (bus.seconds_left <= 4'd1) begin
                     bus.seconds_left <= 4'd0;
                     bus.turn         <= 1'b1;
                     state            <= PC_TURN;
                  end else begin
                     bus.seconds_left <= bus.seconds_left - 4'd1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            PC_TURN: begin
               if (bus.pc_valid && pc_ok) begin
                  bus.shot_row    <= bus.pc_row;
                  bus.shot_col    <= bus.pc_col;
                  bus.shot_target <= 1'b1;
                  bus.shot_valid  <= 1'b1;
                  state           <= PC_SHOT;
               end
            end
            P_SHOT: begin
               if (bus.shot_done) begin
                  bus.shot_valid <= 1'b0;
                  if (bus.shot_repeat) begin
                     state <= P_TURN;
                  end else if (bus.shot_hit && p_inc == WIN) begin
                     bus.player_score <= p_inc;
                     bus.player_win   <= 1'b1;
                     state            <= GAME_OVER;
                  end else begin
                     if (bus.shot_hit) bus.player_score <= p_inc;
                     if (again) begin
                        bus.seconds_left <= SECS;
                        tick             <= '0;
                        state            <= P_TURN;
                     end else begin
                        bus.turn <= 1'b1;
                        state    <= PC_TURN;
                     end
                  end
               end
            end
            PC_SHOT: begin
               if (bus.shot_done) begin
                  bus.shot_valid <= 1'b0;
                  if (bus.shot_repeat) begin
                     state <= PC_TURN;
                  end else if (bus.shot_hit && pc_inc == WIN) begin
                     bus.pc_score    <= pc_inc;
                     bus.player_lose <= 1'b1;
                     state           <= GAME_OVER;
                  end else begin
                     if (bus.shot_hit) bus.pc_score <= pc_inc;
                     if (again) begin
                        state <= PC_TURN;
                     end else begin
                        bus.seconds_left <= SECS;
                        bus.turn         <= 1'b0;
                        tick             <= '0;
                        state            <= P_TURN;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Scoreboard bench for battleship_turn_ctrl: stimulus queues expected shots and status
// snapshots, a negedge monitor pops and compares them.
module tb_battleship_turn_ctrl;
   localparam int TICK  = 4;
   localparam int TS    = 3;
   localparam int SHIPS = 5;
`ifdef BONUS_TURN_EN
   localparam bit BONUS = 1'b1;
`else
   localparam bit BONUS = 1'b0;
`endif

   typedef struct {
      string nm;
      int    at;
      bit    t;
      int    sl;   // -1: not checked
      int    ps;
      int    pcs;
      bit    w;
      bit    l;
      bit    sv;
   } st_t;

   typedef struct {
      int tgt;
      int row;
      int col;
   } shot_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   fin_req = 1'b0;

   st_t   st_q[$];
   shot_t shot_q[$];
   shot_t cur;
   bit    have_cur = 1'b0;
   bit    prev_sv  = 1'b0;

   int ps_m = 0, pcs_m = 0;
   bit win_m = 1'b0, lose_m = 1'b0;

   battleship_turn_ctrl_if bif ();

   battleship_turn_ctrl #(.TICK_CYCLES(TICK), .TURN_SECONDS(TS), .SHIPS(SHIPS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_st(input string nm, input int at, input bit t, input int sl, input bit sv);
      st_t e;
      e.nm = nm; e.at = at; e.t = t; e.sl = sl; e.ps = ps_m; e.pcs = pcs_m;
      e.w = win_m; e.l = lose_m; e.sv = sv;
      st_q.push_back(e);
   endtask

   task automatic exp_shot(input int tgt, input int r, input int c);
      shot_t s;
      s.tgt = tgt; s.row = r; s.col = c;
      shot_q.push_back(s);
   endtask

   task automatic p_shot(input string nm, input int r, input int c, input int hold,
                         input bit hit, input bit rep, input int sl_shot);
      bif.fire_req = 1'b1; bif.sel_row = 3'(r); bif.sel_col = 3'(c);
      exp_shot(0, r, c);
      clk_n(1);
      bif.fire_req = 1'b0;
      exp_st({nm, "_req"}, cyc, 1'b0, sl_shot, 1'b1);
      clk_n(hold);
      bif.shot_done = 1'b1; bif.shot_hit = hit; bif.shot_repeat = rep;
      clk_n(1);
      bif.shot_done = 1'b0; bif.shot_hit = 1'b0; bif.shot_repeat = 1'b0;
      if (rep) begin
         exp_st({nm, "_void"}, cyc, 1'b0, sl_shot, 1'b0);
      end else begin
         if (hit) ps_m++;
         if (ps_m == SHIPS) begin
            win_m = 1'b1;
            exp_st({nm, "_win"}, cyc, 1'b0, -1, 1'b0);
         end else if (hit && BONUS) exp_st({nm, "_bonus"}, cyc, 1'b0, TS, 1'b0);
         else exp_st({nm, "_pass"}, cyc, 1'b1, -1, 1'b0);
      end
   endtask

   task automatic pc_shot(input string nm, input int r, input int c, input bit hit, input bit rep);
      bif.pc_valid = 1'b1; bif.pc_row = 3'(r); bif.pc_col = 3'(c);
      exp_shot(1, r, c);
      clk_n(1);
      bif.pc_valid = 1'b0;
      exp_st({nm, "_req"}, cyc, 1'b1, -1, 1'b1);
      bif.shot_done = 1'b1; bif.shot_hit = hit; bif.shot_repeat = rep;
      clk_n(1);
      bif.shot_done = 1'b0; bif.shot_hit = 1'b0; bif.shot_repeat = 1'b0;
      if (rep) begin
         exp_st({nm, "_void"}, cyc, 1'b1, -1, 1'b0);
      end else begin
         if (hit) pcs_m++;
         if (pcs_m == SHIPS) begin
            lose_m = 1'b1;
            exp_st({nm, "_lose"}, cyc, 1'b1, -1, 1'b0);
         end else if (hit && BONUS) exp_st({nm, "_bonus"}, cyc, 1'b1, -1, 1'b0);
         else exp_st({nm, "_pass"}, cyc, 1'b0, TS, 1'b0);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (bif.shot_valid === 1'b1) begin
         if (!prev_sv) begin
            if (shot_q.size() == 0) begin
               n_tests++; n_fail++; have_cur = 1'b0;
               $display("FAIL shot_unexpected cyc=%0d: got tgt=%0d row=%0d col=%0d, required no shot",
                        cyc, bif.shot_target, bif.shot_row, bif.shot_col);
            end else begin
               cur = shot_q.pop_front();
               have_cur = 1'b1;
            end
         end
         if (have_cur) begin
            n_tests++;
            if (int'(bif.shot_target) != cur.tgt || int'(bif.shot_row) != cur.row ||
                int'(bif.shot_col) != cur.col) begin
               n_fail++;
               $display("FAIL shot_addr cyc=%0d: got tgt=%0d row=%0d col=%0d, required tgt=%0d row=%0d col=%0d",
                        cyc, bif.shot_target, bif.shot_row, bif.shot_col, cur.tgt, cur.row, cur.col);
            end
         end
      end
      prev_sv = (bif.shot_valid === 1'b1);

      for (int i = st_q.size() - 1; i >= 0; i--) begin
         if (st_q[i].at <= cyc) begin
            st_t e;
            e = st_q[i];
            st_q.delete(i);
            n_tests++;
            if (e.at < cyc || bif.turn !== e.t || (e.sl >= 0 && int'(bif.seconds_left) != e.sl) ||
                int'(bif.player_score) != e.ps || int'(bif.pc_score) != e.pcs ||
                bif.player_win !== e.w || bif.player_lose !== e.l || bif.shot_valid !== e.sv) begin
               n_fail++;
               $display("FAIL %s cyc=%0d: got turn=%0d sl=%0d ps=%0d pcs=%0d win=%0d lose=%0d sv=%0d, required turn=%0d sl=%0d ps=%0d pcs=%0d win=%0d lose=%0d sv=%0d at cyc %0d",
                        e.nm, cyc, bif.turn, bif.seconds_left, bif.player_score, bif.pc_score,
                        bif.player_win, bif.player_lose, bif.shot_valid,
                        e.t, e.sl, e.ps, e.pcs, e.w, e.l, e.sv, e.at);
            end
         end
      end

      if (fin_req) begin
         n_tests++;
         if (st_q.size() != 0 || shot_q.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: got status=%0d shots=%0d pending, required 0 and 0",
                     st_q.size(), shot_q.size());
         end
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by time %0t, required completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bif.start = 1'b0; bif.fire_req = 1'b0; bif.sel_row = 3'd0; bif.sel_col = 3'd0;
      bif.pc_valid = 1'b0; bif.pc_row = 3'd0; bif.pc_col = 3'd0;
      bif.shot_done = 1'b0; bif.shot_hit = 1'b0; bif.shot_repeat = 1'b0;
      clk_n(3);
      exp_st("reset", cyc, 1'b0, 0, 1'b0);

      // Timer countdown and forfeit
      rst = 1'b0; bif.start = 1'b1;
      clk_n(1);
      bif.start = 1'b0;
      exp_st("tmr3", cyc, 1'b0, 3, 1'b0);
      exp_st("tmr2", cyc + 4, 1'b0, 2, 1'b0);
      exp_st("tmr1", cyc + 8, 1'b0, 1, 1'b0);
      exp_st("forfeit", cyc + 12, 1'b1, 0, 1'b0);
      clk_n(12);

      // Out-of-range PC cell is ignored, then a PC miss hands the turn back
      bif.pc_valid = 1'b1; bif.pc_row = 3'd5; bif.pc_col = 3'd0;
      clk_n(1);
      bif.pc_valid = 1'b0;
      exp_st("pc_oor", cyc, 1'b1, 0, 1'b0);
      pc_shot("pc_miss", 1, 4, 1'b0, 1'b0);

      // Out-of-range fire ignored, timer keeps running
      bif.fire_req = 1'b1; bif.sel_row = 3'd5; bif.sel_col = 3'd1;
      clk_n(1);
      bif.fire_req = 1'b0;
      exp_st("fire_oor", cyc, 1'b0, 3, 1'b0);
      exp_st("oor_tick", cyc + 3, 1'b0, 2, 1'b0);
      clk_n(3);

      // Held shot with void result: timer resumes frozen value
      p_shot("void", 2, 3, 5, 1'b0, 1'b1, 2);
      exp_st("resume", cyc + 4, 1'b0, 1, 1'b0);
      clk_n(7);

      // Fire on the forfeit tick: fire wins
      p_shot("last_tick", 0, 0, 0, 1'b1, 1'b0, 1);

      // PC wins, interleaved with player misses
`ifdef BONUS_TURN_EN
      p_shot("p_miss_b", 4, 4, 0, 1'b0, 1'b0, TS);
`endif
      pc_shot("pc_void", 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         pc_shot("pc_hit", i, i, 1'b1, 1'b0);
         if (!BONUS && i < 4) p_shot("p_miss", i, 0, 0, 1'b0, 1'b0, TS);
      end

      // GAME_OVER ignores shot requests
      bif.fire_req = 1'b1; bif.sel_row = 3'd1; bif.sel_col = 3'd1;
      bif.pc_valid = 1'b1; bif.pc_row = 3'd1; bif.pc_col = 3'd1;
      clk_n(2);
      bif.fire_req = 1'b0; bif.pc_valid = 1'b0;
      exp_st("over_hold", cyc, 1'b1, -1, 1'b0);

      bif.start = 1'b1;
      clk_n(1);
      bif.start = 1'b0;
      ps_m = 0; pcs_m = 0; win_m = 1'b0; lose_m = 1'b0;
      exp_st("restart", cyc, 1'b0, TS, 1'b0);

      // Player wins
      for (int i = 0; i < 5; i++) begin
         p_shot("p_hit", i, 4 - i, 0, 1'b1, 1'b0, TS);
         if (!BONUS && i < 4) pc_shot("pc_miss2", i, 1, 1'b0, 1'b0);
      end
      bif.start = 1'b1;
      clk_n(1);
      bif.start = 1'b0;
      ps_m = 0; pcs_m = 0; win_m = 1'b0; lose_m = 1'b0;
      exp_st("restart2", cyc, 1'b0, TS, 1'b0);

      // Reset in the middle of a shot
      bif.fire_req = 1'b1; bif.sel_row = 3'd3; bif.sel_col = 3'd2;
      exp_shot(0, 3, 2);
      clk_n(1);
      bif.fire_req = 1'b0;
      exp_st("pre_rst", cyc, 1'b0, TS, 1'b1);
      rst = 1'b1;
      clk_n(1);
      rst = 1'b0;
      exp_st("mid_rst", cyc, 1'b0, 0, 1'b0);
      bif.fire_req = 1'b1; bif.sel_row = 3'd1; bif.sel_col = 3'd1;
      clk_n(1);
      bif.fire_req = 1'b0;
      clk_n(1);
      exp_st("idle_fire", cyc, 1'b0, 0, 1'b0);
      clk_n(2);
      fin_req = 1'b1;
   end
endmodule
